// File: rtl/bus_slave_regs.sv
// bus_slave_regs: bus-slave register bank with programmable wait states, read-only ID at reg 0 and control export of reg 1
module bus_slave_regs #(
  parameter int          REG_ADDR_W = 3,
  parameter int          WAIT_CYC   = 1,
  parameter logic [31:0] ID_VALUE   = 32'h0000_A5A5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic [31:0] ctrl_out
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, next;
  logic [3:0] cnt, cnt_next;
  logic [REG_ADDR_W-1:0] idx_h, idx;
  logic rw_h, rw_c;
  logic [31:0] wd_h, wd;
  logic [31:0] regs [2**REG_ADDR_W];
  logic req, enter_ack, unused_addr;
  assign req = !cs_ && !as_;
  assign unused_addr = ^addr[29:REG_ADDR_W];
  // With zero wait states ACK is entered on the capture edge itself, so use the live bus then
  assign idx = state == IDLE ? addr[REG_ADDR_W-1:0] : idx_h;
  assign rw_c = state == IDLE ? rw : rw_h;
  assign wd = state == IDLE ? wr_data : wd_h;
  assign enter_ack = next == ACK && state != ACK;
  assign ctrl_out = regs[1];
  // Next-state and wait-counter logic; a strobe drop during WAIT aborts the transfer
  always_comb begin
    next = state;
    cnt_next = cnt;
    case (state)
      IDLE: if (req) begin
        next = WAIT_CYC == 0 ? ACK : WAIT;
        cnt_next = WAIT_CYC == 0 ? 4'd0 : 4'(WAIT_CYC - 1);
      end
      WAIT: begin
        next = !req ? IDLE : cnt == 4'd0 ? ACK : WAIT;
        cnt_next = req && cnt != 4'd0 ? cnt - 4'd1 : cnt;
      end
      default: next = IDLE;
    endcase
  end
  // State, counter and request holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx_h <= '0;
      rw_h <= 1'b0;
      wd_h <= '0;
    end else begin
      state <= next;
      cnt <= cnt_next;
      if (state == IDLE && req) begin
        idx_h <= addr[REG_ADDR_W-1:0];
        rw_h <= rw;
        wd_h <= wr_data;
      end
    end
  end
  // Register bank; writes land on the edge entering ACK, index 0 is read-only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
    end else if (enter_ack && !rw_c && idx != '0) begin
      regs[idx] <= wd;
    end
  end
  // Registered response: rdy_ low only in ACK, rd_data non-zero only during a read ACK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_ <= 1'b1;
      rd_data <= '0;
    end else begin
      rdy_ <= !enter_ack;
      rd_data <= enter_ack && rw_c ? (idx == '0 ? ID_VALUE : regs[idx]) : '0;
    end
  end
endmodule

// File: tb/tb_bus_slave_regs.sv
// tb_bus_slave_regs: directed scoreboard bench over three instances with 1, 3 and 0 wait states
module tb_bus_slave_regs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] cs_ = 3'b111;
  logic as_ = 1'b1;
  logic rw = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data [3];
  logic rdy_ [3];
  logic [31:0] ctrl_out [3];
  logic [31:0] sb [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_slave_regs #(.WAIT_CYC(1)) u0 (.clk(clk), .reset(reset), .cs_(cs_[0]), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[0]), .rdy_(rdy_[0]), .ctrl_out(ctrl_out[0]));
  bus_slave_regs #(.WAIT_CYC(3)) u1 (.clk(clk), .reset(reset), .cs_(cs_[1]), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[1]), .rdy_(rdy_[1]), .ctrl_out(ctrl_out[1]));
  bus_slave_regs #(.WAIT_CYC(0)) u2 (.clk(clk), .reset(reset), .cs_(cs_[2]), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[2]), .rdy_(rdy_[2]), .ctrl_out(ctrl_out[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (sb.size() > 0) chk(tag, obs, sb.pop_front());
    else chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
  endtask

  task automatic xact(input int sel, input logic r, input logic [29:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    cs_[sel] = 1'b0;
    as_ = 1'b0;
    rw = r;
    addr = a;
    wr_data = d;
    sb.push_back(exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_[sel] !== 1'b0 && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    if (rdy_[sel] === 1'b0) pop_chk({tag, "_rd_data"}, rd_data[sel]);
    else void'(sb.pop_front());
    cs_[sel] = 1'b1;
    as_ = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy_after"}, 32'(rdy_[sel]), 32'd1);
    chk({tag, "_rd_after"}, rd_data[sel], 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rdy", 32'(rdy_[0]), 32'd1);
    chk("reset_rd", rd_data[0], 32'd0);
    chk("reset_ctrl", ctrl_out[0], 32'd0);
    reset = 1'b0;
    xact(0, 1'b1, 30'd0, 32'd0, 32'h0000_A5A5, 2, "read_id");
    xact(0, 1'b0, 30'd1, 32'hDEAD_BEEF, 32'd0, 2, "write_ctrl");
    chk("ctrl_out", ctrl_out[0], 32'hDEAD_BEEF);
    xact(0, 1'b1, 30'd1, 32'd0, 32'hDEAD_BEEF, 2, "read_ctrl");
    xact(0, 1'b0, 30'd0, 32'h0000_1234, 32'd0, 2, "write_id");
    xact(0, 1'b1, 30'd0, 32'd0, 32'h0000_A5A5, 2, "read_id_ro");
    @(negedge clk);
    cs_[0] = 1'b0;
    as_ = 1'b0;
    rw = 1'b0;
    addr = 30'd3;
    wr_data = 32'h0000_0055;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midwait_rst_rdy", 32'(rdy_[0]), 32'd1);
    chk("midwait_rst_rd", rd_data[0], 32'd0);
    chk("midwait_rst_ctrl", ctrl_out[0], 32'd0);
    cs_[0] = 1'b1;
    as_ = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    xact(0, 1'b1, 30'd3, 32'd0, 32'd0, 2, "read_after_rst");
    @(negedge clk);
    cs_[1] = 1'b0;
    as_ = 1'b0;
    rw = 1'b0;
    addr = 30'd5;
    wr_data = 32'h0000_FFFF;
    @(negedge clk);
    chk("abort_wait_rdy", 32'(rdy_[1]), 32'd1);
    as_ = 1'b1;
    cs_[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_rdy", 32'(rdy_[1]), 32'd1);
    end
    xact(1, 1'b1, 30'd5, 32'd0, 32'd0, 4, "read_after_abort");
    xact(2, 1'b0, 30'd4, 32'h0000_0099, 32'd0, 1, "w0_write");
    @(negedge clk);
    cs_[2] = 1'b0;
    as_ = 1'b0;
    rw = 1'b1;
    addr = 30'd4;
    repeat (3) sb.push_back(32'h0000_0099);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("held_rdy", 32'(rdy_[2]), k % 2 == 0 ? 32'd0 : 32'd1);
      if (rdy_[2] === 1'b0) pop_chk("held_rd", rd_data[2]);
    end
    cs_[2] = 1'b1;
    as_ = 1'b1;
    chk("held_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    xact(0, 1'b0, 30'h1000_0002, 32'h0000_0077, 32'd0, 2, "alias_write");
    xact(0, 1'b1, 30'd2, 32'd0, 32'h0000_0077, 2, "alias_read");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
